fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request handshake, one-entry skid buffer
// for stalls, branch/jump redirect with response dropping, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_d,
    input  logic        pcsrc_m,
    input  logic [31:0] pcbranch_m,
    input  logic        jump_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [5:0]  op_d,
    output logic [5:0]  funct_d
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StDrop  = 2'd3
    } state_e;

    state_e      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    // Redirect target remembered while the stale request drains in DROP.
    logic [31:0] pc_tgt_q, pc_tgt_n;
    logic [31:0] buf_instr_q, buf_instr_n;
    logic [31:0] buf_pc4_q, buf_pc4_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc4_q, pc4_n;
    logic        valid_q, valid_n;

    logic [31:0] pc_plus4;
    logic        redirect_jump;
    logic        redirect;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc4;

    // Redirect detection and target selection; a resolved branch outranks a decoded jump.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        redirect_jump = jump_d & valid_q & ~stall_d;
        redirect      = pcsrc_m | redirect_jump;
        if (pcsrc_m) begin
            target = {pcbranch_m[31:2], 2'b00};
        end else begin
            target = {pc4_q[31:28], instr_q[25:0], 2'b00};
        end
    end

    // Next-state, PC and buffer updates plus the memory request.
    always_comb begin
        state_n       = state_q;
        pc_n          = pc_q;
        pc_tgt_n      = pc_tgt_q;
        buf_instr_n   = buf_instr_q;
        buf_pc4_n     = buf_pc4_q;
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;
        deliver_pc4   = pc4_q;

        unique case (state_q)
            StBoot: begin
                state_n = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if (imem_ready) begin
                        pc_n = target;
                    end else begin
                        pc_tgt_n = target;
                        state_n  = StDrop;
                    end
                end else if (imem_ready) begin
                    if (stall_d) begin
                        // Park the word; PC advances once it actually enters IF/ID.
                        buf_instr_n = imem_rdata;
                        buf_pc4_n   = pc_plus4;
                        state_n     = StHold;
                    end else begin
                        pc_n          = pc_plus4;
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        deliver_pc4   = pc_plus4;
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = StFetch;
                end else if (!stall_d) begin
                    pc_n          = pc_plus4;
                    deliver       = 1'b1;
                    deliver_instr = buf_instr_q;
                    deliver_pc4   = buf_pc4_q;
                    state_n       = StFetch;
                end
            end
            StDrop: begin
                // Keep the old address on the bus until the stale response arrives.
                imem_req = 1'b1;
                if (redirect) begin
                    pc_tgt_n = target;
                end
                if (imem_ready) begin
                    pc_n    = redirect ? target : pc_tgt_q;
                    state_n = StFetch;
                end
            end
            default: begin
                state_n = StBoot;
            end
        endcase
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load a word or a bubble.
    always_comb begin
        instr_n = instr_q;
        pc4_n   = pc4_q;
        valid_n = valid_q;
        if (pcsrc_m) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
        end else if (!stall_d) begin
            if (deliver) begin
                instr_n = deliver_instr;
                pc4_n   = deliver_pc4;
                valid_n = 1'b1;
            end else begin
                instr_n = NOP_INSTR;
                valid_n = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            pc_tgt_q    <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= 32'd0;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            pc_tgt_q    <= pc_tgt_n;
            buf_instr_q <= buf_instr_n;
            buf_pc4_q   <= buf_pc4_n;
            instr_q     <= instr_n;
            pc4_q       <= pc4_n;
            valid_q     <= valid_n;
        end
    end

    // Output wiring.
    always_comb begin
        imem_addr = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pc4_q;
        valid_d   = valid_q;
        op_d      = instr_q[31:26];
        funct_d   = instr_q[5:0];
    end

endmodule
